// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl: next fetch-PC selection with vectored interrupt entry.
// In RUN the next PC is picked from the redirect candidates by a fixed
// priority. An eligible interrupt first saves the return PC in epc. It then
// drains the pipeline for FLUSH_CYCLES cycles with flush high and fetch held
// at pc. On the last drain cycle fetch is vectored to
// VECTOR_BASE + irq_id*VECTOR_STRIDE.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pc .. pci             candidate next-PC values (XLEN each)
//   stall .. pci_take     redirect selects
//   rti                   return from interrupt (redirect to epc)
//   irq, irq_mask         rising-edge interrupt lines, per-source mask
//   global_ie             global interrupt enable
//   pc_out                next fetch PC (combinational)
//   flush                 high for the whole drain
//   interrupt, irq_ack    one-cycle vector pulse, one-hot acknowledge
//   irq_id, epc, in_isr   serviced source, saved return PC, handler active
module next_pc_ctrl #(
  parameter int XLEN          = 32,
  parameter int NUM_IRQ       = 4,
  parameter int FLUSH_CYCLES  = 4,
  parameter int VECTOR_BASE   = 1024,
  parameter int VECTOR_STRIDE = 16,
  parameter int RESET_PC      = 0,
  localparam int IDW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    pc_plus_4,
  input  logic [XLEN-1:0]    branch_pc,
  input  logic [XLEN-1:0]    pc_not_taken,
  input  logic [XLEN-1:0]    pcr,
  input  logic [XLEN-1:0]    pci,
  input  logic               stall,
  input  logic               branch_undo,
  input  logic               pcr_take,
  input  logic               branch_predict,
  input  logic               pci_take,
  input  logic               rti,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               global_ie,
  output logic [XLEN-1:0]    pc_out,
  output logic               flush,
  output logic               interrupt,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [IDW-1:0]     irq_id,
  output logic [XLEN-1:0]    epc,
  output logic               in_isr
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {ST_SR, ST_RUN, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [IDW-1:0]     irq_id_q, irq_id_d;
  logic               in_isr_q, in_isr_d;

  logic [XLEN-1:0]    run_pc;
  logic [XLEN-1:0]    vec_pc;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] pending_clr;
  logic [IDW-1:0]     low_id;
  logic               rti_taken;
  logic               last_drain;

  always_comb begin
    if (stall)               run_pc = pc;
    else if (branch_undo)    run_pc = pc_not_taken;
    else if (rti)            run_pc = epc_q;
    else if (pcr_take)       run_pc = pcr;
    else if (branch_predict) run_pc = branch_pc;
    else if (pci_take)       run_pc = pci;
    else                     run_pc = pc_plus_4;
  end

  always_comb begin
    eligible = pending_q & ~irq_mask;
    // Descending scan so the lowest-index eligible source is written last.
    low_id = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (eligible[i-1]) low_id = IDW'(i - 1);
    end
  end

  assign rti_taken  = rti & ~stall & ~branch_undo;
  assign last_drain = (cnt_q == CW'(FLUSH_CYCLES - 1));
  assign id_onehot  = NUM_IRQ'(1) << irq_id_q;
  assign vec_pc     = XLEN'(VECTOR_BASE) + XLEN'(irq_id_q) * XLEN'(VECTOR_STRIDE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    irq_id_d    = irq_id_q;
    in_isr_d    = in_isr_q;
    pending_clr = '0;
    pc_out      = XLEN'(RESET_PC);
    flush       = 1'b0;
    interrupt   = 1'b0;
    irq_ack     = '0;
    unique case (state_q)
      ST_SR: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_out = run_pc;
        if (rti_taken) in_isr_d = 1'b0;
        if (global_ie && !in_isr_q && (|eligible) && !rti_taken) begin
          epc_d    = run_pc;
          irq_id_d = low_id;
          cnt_d    = '0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        // Redirects resolving during the drain retarget the return address.
        if (branch_undo)         epc_d = pc_not_taken;
        else if (pcr_take)       epc_d = pcr;
        else if (branch_predict) epc_d = branch_pc;
        if (last_drain) begin
          pc_out      = vec_pc;
          interrupt   = 1'b1;
          irq_ack     = id_onehot;
          pending_clr = id_onehot;
          in_isr_d    = 1'b1;
          state_d     = ST_RUN;
        end else begin
          pc_out = pc;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_SR;
    endcase
    // A fresh rising edge outranks the acknowledge clear.
    pending_d = (pending_q & ~pending_clr) | (irq & ~irq_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SR;
      pending_q  <= '0;
      irq_prev_q <= '0;
      cnt_q      <= '0;
      epc_q      <= '0;
      irq_id_q   <= '0;
      in_isr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq;
      cnt_q      <= cnt_d;
      epc_q      <= epc_d;
      irq_id_q   <= irq_id_d;
      in_isr_q   <= in_isr_d;
    end
  end

  assign irq_id = irq_id_q;
  assign epc    = epc_q;
  assign in_isr = in_isr_q;

endmodule

// File: tb/tb_next_pc_ctrl.sv
module tb_next_pc_ctrl;

  localparam int NI = 4;
  localparam int FC = 4;
  localparam int VB = 1024;
  localparam int VS = 16;
  localparam int RP = 0;

  logic clk;
  logic rst;
  logic [31:0] pc, pc_plus_4, branch_pc, pc_not_taken, pcr, pci;
  logic stall, branch_undo, pcr_take, branch_predict, pci_take, rti, global_ie;
  logic [NI-1:0] irq, irq_mask;
  logic [31:0] pc_out, epc;
  logic flush, interrupt, in_isr;
  logic [NI-1:0] irq_ack;
  logic [1:0] irq_id;

  int n_checks = 0;
  int n_err    = 0;

  next_pc_ctrl #(
    .XLEN(32), .NUM_IRQ(NI), .FLUSH_CYCLES(FC),
    .VECTOR_BASE(VB), .VECTOR_STRIDE(VS), .RESET_PC(RP)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_plus_4(pc_plus_4),
    .branch_pc(branch_pc), .pc_not_taken(pc_not_taken), .pcr(pcr), .pci(pci),
    .stall(stall), .branch_undo(branch_undo), .pcr_take(pcr_take),
    .branch_predict(branch_predict), .pci_take(pci_take), .rti(rti),
    .irq(irq), .irq_mask(irq_mask), .global_ie(global_ie),
    .pc_out(pc_out), .flush(flush), .interrupt(interrupt), .irq_ack(irq_ack),
    .irq_id(irq_id), .epc(epc), .in_isr(in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = reset, 1 = running, 2 = draining.
  int          m_mode  = 0;
  bit          m_valid = 0;
  logic [NI-1:0] m_pend, m_prev;
  int          m_cnt, m_id;
  logic [31:0] m_epc;
  bit          m_isr;

  function automatic logic [31:0] pick();
    if (stall)          return pc;
    if (branch_undo)    return pc_not_taken;
    if (rti)            return m_epc;
    if (pcr_take)       return pcr;
    if (branch_predict) return branch_pc;
    if (pci_take)       return pci;
    return pc_plus_4;
  endfunction

  logic [31:0]   e_pc;
  bit            e_fl, e_int, rti_t;
  logic [NI-1:0] e_ack, elig, rises;
  int            low;

  always @(negedge clk) begin
    e_pc = RP; e_fl = 0; e_int = 0; e_ack = '0;
    if (m_mode == 1) e_pc = pick();
    if (m_mode == 2) begin
      e_fl = 1;
      if (m_cnt == FC - 1) begin
        e_pc  = VB + m_id * VS;
        e_int = 1;
        e_ack = NI'(1 << m_id);
      end else e_pc = pc;
    end
    if (m_valid) begin
      chk("pc_out", pc_out, e_pc);
      chk("flush", flush, e_fl);
      chk("interrupt", interrupt, e_int);
      chk("irq_ack", irq_ack, e_ack);
      chk("irq_id", irq_id, m_id);
      chk("epc", epc, m_epc);
      chk("in_isr", in_isr, m_isr);
    end
    if (rst) begin
      m_valid = 1; m_mode = 0; m_pend = '0; m_prev = '0;
      m_cnt = 0; m_epc = '0; m_id = 0; m_isr = 0;
    end else if (m_valid) begin
      rises = irq & ~m_prev;
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        rti_t = rti && !stall && !branch_undo;
        elig  = m_pend & ~irq_mask;
        low   = -1;
        for (int i = 0; i < NI; i++) if (elig[i] && low < 0) low = i;
        if (global_ie && !m_isr && low >= 0 && !rti_t) begin
          m_epc = pick(); m_id = low; m_cnt = 0; m_mode = 2;
        end
        if (rti_t) m_isr = 0;
      end else begin
        if (branch_undo)         m_epc = pc_not_taken;
        else if (pcr_take)       m_epc = pcr;
        else if (branch_predict) m_epc = branch_pc;
        if (m_cnt == FC - 1) begin
          m_pend[m_id] = 1'b0; m_isr = 1; m_mode = 1;
        end else m_cnt++;
      end
      m_pend = m_pend | rises;
      m_prev = irq;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall = 0; branch_undo = 0; pcr_take = 0; branch_predict = 0;
    pci_take = 0; rti = 0; global_ie = 1; irq_mask = '0;
  endtask

  initial begin
    rst = 1; irq = '0; quiet();
    pc = 32'h1234; pc_plus_4 = 32'h1238; branch_pc = 32'h3000;
    pc_not_taken = 32'h4000; pcr = 32'h5000; pci = 32'h6000;
    step(); step();
    rst = 0; #1;
    chk("rst_pc", pc_out, RP);
    chk("rst_flush", flush, 0);
    chk("rst_epc", epc, 0);
    chk("rst_isr", in_isr, 0);
    chk("rst_id", irq_id, 0);
    step(); #1;
    chk("run_pc4", pc_out, 32'h1238);
    stall = 1; branch_undo = 1; #1;
    chk("stall_prio", pc_out, 32'h1234);
    stall = 0; branch_undo = 0; pcr_take = 1; branch_predict = 1; #1;
    chk("pcr_prio", pc_out, 32'h5000);
    pcr_take = 0; branch_predict = 0;

    // irq[2] single source
    pc_plus_4 = 32'h100; irq = 4'b0100;
    step(); #1;
    chk("entry_pc", pc_out, 32'h100);
    step(); #1;
    chk("d0_flush", flush, 1);
    chk("d0_epc", epc, 32'h100);
    chk("d0_pc", pc_out, 32'h1234);
    step(); step(); step(); #1;
    chk("vec_flush", flush, 1);
    chk("vec_pc", pc_out, 32'd1056);
    chk("vec_int", interrupt, 1);
    chk("vec_ack", irq_ack, 4'b0100);
    step(); #1;
    chk("isr_set", in_isr, 1);
    chk("post_int", interrupt, 0);
    chk("post_id", irq_id, 2);
    rti = 1; #1;
    chk("rti_pc", pc_out, 32'h100);
    step(); rti = 0; irq = '0; #1;
    chk("rti_isr", in_isr, 0);

    // irq[3] and irq[1] together: lowest first
    irq = 4'b1010;
    step(); step(); #1;
    chk("two_id1", irq_id, 1);
    step(); step(); step(); #1;
    chk("two_ack1", irq_ack, 4'b0010);
    step(); step(); #1;
    chk("blocked", flush, 0);
    rti = 1;
    step(); rti = 0;
    step(); #1;
    chk("two_id3", irq_id, 3);
    step(); step(); step(); #1;
    chk("two_ack3", irq_ack, 4'b1000);
    chk("two_vec3", pc_out, 32'd1072);
    step(); rti = 1;
    step(); rti = 0; irq = '0;

    // branch_undo during drain retargets epc
    irq = 4'b0001;
    step(); step(); step();
    branch_undo = 1; pc_not_taken = 32'h200; #1;
    chk("drain_hold", pc_out, 32'h1234);
    step(); branch_undo = 0; #1;
    chk("drain_epc", epc, 32'h200);
    step(); #1;
    chk("vec0", pc_out, 32'd1024);
    step(); rti = 1; #1;
    chk("rti_epc", pc_out, 32'h200);
    step(); rti = 0; irq = '0; #1;
    chk("rti_clr", in_isr, 0);

    // reset in second drain cycle
    irq = 4'b0100;
    step(); step(); step();
    rst = 1; irq = '0; #1;
    chk("abort_int", interrupt, 0);
    step(); rst = 0; #1;
    chk("abort_pc", pc_out, RP);
    chk("abort_flush", flush, 0);
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk("no_reentry", flush | interrupt, 0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      pc = $urandom; pc_plus_4 = $urandom; branch_pc = $urandom;
      pc_not_taken = $urandom; pcr = $urandom; pci = $urandom;
      stall          = ($urandom_range(0, 5) == 0);
      branch_undo    = ($urandom_range(0, 5) == 0);
      pcr_take       = ($urandom_range(0, 5) == 0);
      branch_predict = ($urandom_range(0, 5) == 0);
      pci_take       = ($urandom_range(0, 5) == 0);
      rti            = ($urandom_range(0, 11) == 0);
      global_ie      = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < NI; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      if ($urandom_range(0, 49) == 0) irq_mask = NI'($urandom);
    end
    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
